bram_acc_engine: RTL and testbench
==================================

Name: bram_acc_engine

Overview:
Parametrised multi-lane streaming accumulator between two single-port BRAMs. It reads run_count consecutive words from BRAM0 starting at a programmable base address. Each word is split into LANES independent lanes, and each lane keeps a running sum. After every read it writes the updated lane sums as one word to BRAM1 at a programmable base address. It sits under the register/controller block and replaces the fixed 4-lane, fixed-latency accessor with a generalised width, lane count, read latency and overflow mode.

Parameters:
LANES, 4, number of accumulator lanes per word
LANE_W, 8, bits per lane; DWIDTH = LANES*LANE_W
AWIDTH, 8, BRAM address width
RD_LAT, 1, BRAM0 read latency in cycles (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start_i  in  1  start pulse; sampled only in IDLE
run_count_i  in  AWIDTH+1  number of words to process (0..2^AWIDTH)
src_base_i  in  AWIDTH  first BRAM0 read address
dst_base_i  in  AWIDTH  first BRAM1 write address
sat_en_i  in  1  1 = saturating lane add, 0 = wrapping
q_b0_i  in  DWIDTH  BRAM0 read data
idle_o / run_o / done_o  out  1 each  state flags
read_o  out  1  BRAM0 read issued this cycle
write_o  out  1  BRAM1 write issued this cycle
addr_b0_o  out  AWIDTH; ce_b0_o out 1; we_b0_o out 1; d_b0_o out DWIDTH  BRAM0 interface
addr_b1_o  out  AWIDTH; ce_b1_o out 1; we_b1_o out 1; d_b1_o out DWIDTH  BRAM1 interface

Behaviour:
- Reset (asynchronous, any time including mid-run):
  - State = IDLE, idle_o = 1.
  - All other outputs 0, all accumulators 0, the read-valid pipeline is cleared, and pending writes are discarded.
- States:
  - IDLE -> RUN when start_i = 1 and run_count_i != 0.
  - IDLE -> DONE when start_i = 1 and run_count_i = 0.
  - RUN -> DRAIN after the last read is issued.
  - DRAIN -> DONE after the last write is issued.
  - DONE -> IDLE unconditionally. done_o is exactly a one-cycle pulse.
- Start capture: at the start edge, latch run_count_i, src_base_i, dst_base_i and sat_en_i, and clear all accumulators. Later changes to these inputs have no effect until the next start. start_i is ignored outside IDLE.
- Reads: in RUN, one read per cycle for k = 0..N-1.
  - addr_b0_o = src_base + k, modulo 2^AWIDTH.
  - ce_b0_o = read_o = 1, we_b0_o = 0.
  - d_b0_o is tied to 0. BRAM0 is never written.
- Data return: q_b0_i is valid exactly RD_LAT cycles after a read. Track this with an RD_LAT-deep valid/index shift register.
- Accumulate: on each valid return, for each lane l, acc[l] <= acc[l] + q_b0_i[l*LANE_W +: LANE_W].
  - Addition is unsigned.
  - sat_en = 1: clamp the result to 2^LANE_W - 1.
  - sat_en = 0: take the result modulo 2^LANE_W.
  - Lanes never carry into each other.
- Writes: on the cycle after each valid return, ce_b1_o = we_b1_o = write_o = 1.
  - addr_b1_o = dst_base + k, modulo 2^AWIDTH.
  - d_b1_o = updated acc, lane l in bits [l*LANE_W +: LANE_W].
  - Write outputs are registered.
  - Outside write cycles, ce_b1_o, we_b1_o and d_b1_o are all 0.
- Timing (start sampled at edge E0):
  - Reads in cycles 1..N.
  - Writes in cycles 1+RD_LAT+1 .. N+RD_LAT+1.
  - done_o in cycle N+RD_LAT+2.
  - idle_o in the following cycle.
  - For N = 0, done_o is in cycle 1 and no ce is ever asserted.
- Flags:
  - idle_o, run_o and done_o are mutually exclusive and one-hot.
  - run_o is high in both RUN and DRAIN.
- Full depth: N = 2^AWIDTH is legal. Read addresses then cover every address once, wrapping from src_base.

Test Plan:
- LANES=4, LANE_W=8, RD_LAT=1; BRAM0[0..3] = 0x01020304; start with N=4, src=0, dst=0x10, sat=0 -> BRAM1[0x10..0x13] = 0x01020304, 0x02040608, 0x0306090C, 0x04080C10; done_o in cycle 7, exactly one cycle wide.
- BRAM0[0..2] = 0x80808080, N=3: sat=0 -> writes 0x80808080, 0x00000000, 0x80808080; sat=1 -> 0x80808080, 0xFFFFFFFF, 0xFFFFFFFF.
- src=0xFE, dst=0xFF, N=4 -> read addresses 0xFE, 0xFF, 0x00, 0x01; write addresses 0xFF, 0x00, 0x01, 0x02; no extra accesses.
- N=0 -> done_o in cycle 1, then idle_o; ce_b0_o and ce_b1_o stay 0. start_i pulsed during RUN of a prior N=4 run -> ignored, exactly 4 writes occur.
- RD_LAT=2 build, same data as scenario 1 -> identical BRAM1 contents, each write 3 cycles after its read, done_o in cycle 8.
- reset_n asserted in cycle 3 of an N=8 run -> outputs immediately reset, idle_o = 1, no further writes; a fresh N=2 run afterwards starts from zeroed accumulators.

Source files
------------

// File: rtl/bram_acc_engine.sv
// Multi-lane streaming accumulator: reads a run of words from BRAM0, keeps a
// per-lane running sum, and writes the updated sums to BRAM1 after every read.
module bram_acc_engine #(
   parameter int LANES  = 4,
   parameter int LANE_W = 8,
   parameter int AWIDTH = 8,
   parameter int RD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start_i,
   input  logic [AWIDTH:0]           run_count_i,
   input  logic [AWIDTH-1:0]         src_base_i,
   input  logic [AWIDTH-1:0]         dst_base_i,
   input  logic                      sat_en_i,
   input  logic [LANES*LANE_W-1:0]   q_b0_i,
   output logic                      idle_o,
   output logic                      run_o,
   output logic                      done_o,
   output logic                      read_o,
   output logic                      write_o,
   output logic [AWIDTH-1:0]         addr_b0_o,
   output logic                      ce_b0_o,
   output logic                      we_b0_o,
   output logic [LANES*LANE_W-1:0]   d_b0_o,
   output logic [AWIDTH-1:0]         addr_b1_o,
   output logic                      ce_b1_o,
   output logic                      we_b1_o,
   output logic [LANES*LANE_W-1:0]   d_b1_o,
   output logic [1:0]                dbg_state_o
);

   // Handshake: none. A read issued in cycle c returns data in cycle
   // c+RD_LAT; the matching BRAM1 write is presented in cycle c+RD_LAT+1.

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

   state_t                              state_q, state_d;
   logic [AWIDTH:0]                     cnt_q, cnt_d;
   logic [AWIDTH:0]                     run_count_q, run_count_d;
   logic [AWIDTH-1:0]                   src_q, src_d;
   logic [AWIDTH-1:0]                   dst_q, dst_d;
   logic                                sat_q, sat_d;
   logic [LANES-1:0][LANE_W-1:0]        acc_q, acc_d;
   logic [RD_LAT-1:0]                   vld_q, vld_d;
   logic [RD_LAT-1:0][AWIDTH-1:0]       idx_q, idx_d;
   logic                                wr_q, wr_d;
   logic [AWIDTH-1:0]                   wr_addr_q, wr_addr_d;
   logic [LANES*LANE_W-1:0]             wr_data_q, wr_data_d;
   logic [LANES-1:0][LANE_W:0]          lane_sum;
   logic                                read;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         run_count_q <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         sat_q       <= 1'b0;
         acc_q       <= '0;
         vld_q       <= '0;
         idx_q       <= '0;
         wr_q        <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         run_count_q <= run_count_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         sat_q       <= sat_d;
         acc_q       <= acc_d;
         vld_q       <= vld_d;
         idx_q       <= idx_d;
         wr_q        <= wr_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      run_count_d = run_count_q;
      src_d       = src_q;
      dst_d       = dst_q;
      sat_d       = sat_q;
      acc_d       = acc_q;
      vld_d       = '0;
      idx_d       = '0;
      wr_d        = 1'b0;
      wr_addr_d   = '0;
      wr_data_d   = '0;
      lane_sum    = '0;
      read        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               run_count_d = run_count_i;
               src_d       = src_base_i;
               dst_d       = dst_base_i;
               sat_d       = sat_en_i;
               acc_d       = '0;
               cnt_d       = '0;
               state_d     = (run_count_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            read  = 1'b1;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == run_count_q - CNT_ONE) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // The last write is the one with nothing left in flight behind it.
            if (wr_q && !(|vld_q)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      vld_d[0] = read;
      idx_d[0] = cnt_q[AWIDTH-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         idx_d[i] = idx_q[i-1];
      end

      if (vld_q[RD_LAT-1]) begin
         for (int l = 0; l < LANES; l++) begin
            lane_sum[l] = {1'b0, acc_q[l]} + {1'b0, q_b0_i[l*LANE_W +: LANE_W]};
            acc_d[l]    = (sat_q && lane_sum[l][LANE_W]) ? {LANE_W{1'b1}}
                                                         : lane_sum[l][LANE_W-1:0];
         end
         wr_d      = 1'b1;
         wr_addr_d = dst_q + idx_q[RD_LAT-1];
         wr_data_d = acc_d;
      end
   end

   assign idle_o      = (state_q == S_IDLE);
   assign run_o       = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done_o      = (state_q == S_DONE);
   assign read_o      = read;
   assign ce_b0_o     = read;
   assign we_b0_o     = 1'b0;
   assign d_b0_o      = '0;
   assign addr_b0_o   = read ? (src_q + cnt_q[AWIDTH-1:0]) : '0;
   assign write_o     = wr_q;
   assign ce_b1_o     = wr_q;
   assign we_b1_o     = wr_q;
   assign addr_b1_o   = wr_addr_q;
   assign d_b1_o      = wr_data_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bram_acc_engine.sv
// Directed bench for bram_acc_engine: a RD_LAT=1 instance for all scenarios
// and a RD_LAT=2 instance for the latency scenario, checked through queues.
module tb_bram_acc_engine;

   localparam int DW = 32;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          start = 1'b0, start2 = 1'b0;
   logic [AW:0]   run_count = '0;
   logic [AW-1:0] src = '0, dst = '0;
   logic          sat = 1'b0;

   logic [DW-1:0] mem0 [256];

   // instance 1 (RD_LAT=1)
   logic [DW-1:0] q1 = '0;
   logic idle_1, run_1, done_1, read_1, write_1, ce_b0_1, we_b0_1, ce_b1_1, we_b1_1;
   logic [AW-1:0] addr_b0_1, addr_b1_1;
   logic [DW-1:0] d_b0_1, d_b1_1;
   logic [1:0]    st_1;

   // instance 2 (RD_LAT=2)
   logic [DW-1:0] q2a = '0, q2b = '0;
   logic idle_2, run_2, done_2, read_2, write_2, ce_b0_2, we_b0_2, ce_b1_2, we_b1_2;
   logic [AW-1:0] addr_b0_2, addr_b1_2;
   logic [DW-1:0] d_b0_2, d_b1_2;
   logic [1:0]    st_2;

   always @(posedge clk) begin
      if (ce_b0_1) q1 <= mem0[addr_b0_1];
      q2a <= mem0[addr_b0_2];
      q2b <= q2a;
   end

   bram_acc_engine #(.LANES(4), .LANE_W(8), .AWIDTH(AW), .RD_LAT(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .start_i(start), .run_count_i(run_count),
      .src_base_i(src), .dst_base_i(dst), .sat_en_i(sat), .q_b0_i(q1),
      .idle_o(idle_1), .run_o(run_1), .done_o(done_1), .read_o(read_1), .write_o(write_1),
      .addr_b0_o(addr_b0_1), .ce_b0_o(ce_b0_1), .we_b0_o(we_b0_1), .d_b0_o(d_b0_1),
      .addr_b1_o(addr_b1_1), .ce_b1_o(ce_b1_1), .we_b1_o(we_b1_1), .d_b1_o(d_b1_1),
      .dbg_state_o(st_1));

   bram_acc_engine #(.LANES(4), .LANE_W(8), .AWIDTH(AW), .RD_LAT(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .start_i(start2), .run_count_i(run_count),
      .src_base_i(src), .dst_base_i(dst), .sat_en_i(sat), .q_b0_i(q2b),
      .idle_o(idle_2), .run_o(run_2), .done_o(done_2), .read_o(read_2), .write_o(write_2),
      .addr_b0_o(addr_b0_2), .ce_b0_o(ce_b0_2), .we_b0_o(we_b0_2), .d_b0_o(d_b0_2),
      .addr_b1_o(addr_b1_2), .ce_b1_o(ce_b1_2), .we_b1_o(we_b1_2), .d_b1_o(d_b1_2),
      .dbg_state_o(st_2));

   // scoreboard
   logic [AW+DW-1:0] exp_q[$];
   logic [AW-1:0]    rd_q[$];
   logic [AW+DW-1:0] exp2_q[$];
   int               wc2_q[$];
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_q.push_back({a, d});
   endtask

   // monitor for instance 1
   always @(negedge clk) begin
      if (reset_n) begin
         if (read_1) begin
            if (rd_q.size() == 0) chk("unexpected_read", {1'b1, addr_b0_1}, 0);
            else chk("rd_addr", addr_b0_1, rd_q.pop_front());
            chk("rd_ctrl", {ce_b0_1, we_b0_1, d_b0_1}, {1'b1, 1'b0, 32'h0});
         end else begin
            chk("b0_quiet", {ce_b0_1, we_b0_1}, 0);
         end
         if (write_1) begin
            if (exp_q.size() == 0) chk("unexpected_write", {addr_b1_1, d_b1_1}, 0);
            else chk("wr_addr_data", {addr_b1_1, d_b1_1}, exp_q.pop_front());
            chk("wr_ctrl", {ce_b1_1, we_b1_1}, 2'b11);
         end else begin
            chk("b1_quiet", {ce_b1_1, we_b1_1, d_b1_1}, 0);
         end
         chk("flags_onehot", $countones({idle_1, run_1, done_1}), 1);
      end
   end

   // monitor for instance 2: write contents and read-to-write spacing
   always @(negedge clk) begin
      if (reset_n) begin
         if (write_2) begin
            if (exp2_q.size() == 0) chk("unexpected_write2", {addr_b1_2, d_b1_2}, 0);
            else chk("wr2_addr_data", {addr_b1_2, d_b1_2}, exp2_q.pop_front());
            if (wc2_q.size() == 0) chk("wr2_no_read", cyc, 0);
            else chk("wr2_cycle", cyc, wc2_q.pop_front());
         end
         if (read_2) wc2_q.push_back(cyc + 3);
      end
   end

   task automatic run_job(input int n, input logic [AW-1:0] s_base, input logic [AW-1:0] d_base,
                          input logic s_en, input bit both, input bit pulse_mid);
      int c, dc1, dc2;
      bit d1, d2, p1, p2;
      for (int k = 0; k < n; k++) rd_q.push_back(s_base + AW'(k));
      @(negedge clk);
      run_count = (AW+1)'(n);
      src = s_base;
      dst = d_base;
      sat = s_en;
      start = 1'b1;
      start2 = both;
      @(posedge clk);
      #1;
      start = 1'b0;
      start2 = 1'b0;
      run_count = '1;
      src = 8'hAA;
      dst = 8'h55;
      sat = ~s_en;
      c = 1; dc1 = 0; dc2 = 0;
      d1 = 0; p1 = 0;
      d2 = !both; p2 = !both;
      while (!(p1 && p2) && c < 600) begin
         @(negedge clk);
         if (pulse_mid) begin
            if (c == 2) begin
               start = 1'b1; run_count = 9'd7; src = 8'h50; dst = 8'h60; sat = 1'b1;
            end else begin
               start = 1'b0;
            end
         end
         if (!d1 && done_1) begin
            d1 = 1; dc1 = c;
            chk("done_cycle", c, (n == 0) ? 1 : n + 3);
         end else if (d1 && !p1 && c == dc1 + 1) begin
            p1 = 1;
            chk("done_pulse_then_idle", {done_1, idle_1}, 2'b01);
         end
         if (!d2 && done_2) begin
            d2 = 1; dc2 = c;
            chk("done2_cycle", c, n + 4);
         end else if (d2 && !p2 && c == dc2 + 1) begin
            p2 = 1;
            chk("done2_pulse_then_idle", {done_2, idle_2}, 2'b01);
         end
         @(posedge clk);
         c++;
      end
      if (!(p1 && p2)) chk("job_timeout", {p1, p2}, 2'b11);
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem0[i] = '0;
      #1;
      chk("reset_flags", {idle_1, run_1, done_1, read_1, write_1}, 5'b10000);
      chk("reset_bus", {ce_b0_1, we_b0_1, ce_b1_1, we_b1_1, addr_b1_1, d_b1_1}, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // accumulate four equal words, wrapping mode; also on the RD_LAT=2 instance
      for (int i = 0; i < 4; i++) mem0[i] = 32'h01020304;
      exp_wr(8'h10, 32'h01020304);
      exp_wr(8'h11, 32'h02040608);
      exp_wr(8'h12, 32'h0306090C);
      exp_wr(8'h13, 32'h04080C10);
      exp2_q.push_back({8'h10, 32'h01020304});
      exp2_q.push_back({8'h11, 32'h02040608});
      exp2_q.push_back({8'h12, 32'h0306090C});
      exp2_q.push_back({8'h13, 32'h04080C10});
      run_job(4, 8'h00, 8'h10, 1'b0, 1'b1, 1'b0);

      // lane overflow: wrap then saturate
      for (int i = 0; i < 3; i++) mem0[i] = 32'h80808080;
      exp_wr(8'h20, 32'h80808080);
      exp_wr(8'h21, 32'h00000000);
      exp_wr(8'h22, 32'h80808080);
      run_job(3, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0);
      exp_wr(8'h20, 32'h80808080);
      exp_wr(8'h21, 32'hFFFFFFFF);
      exp_wr(8'h22, 32'hFFFFFFFF);
      run_job(3, 8'h00, 8'h20, 1'b1, 1'b0, 1'b0);

      // address wrap on both ports
      mem0[8'hFE] = 32'h00000001;
      mem0[8'hFF] = 32'h00000002;
      exp_wr(8'hFF, 32'h00000001);
      exp_wr(8'h00, 32'h00000003);
      exp_wr(8'h01, 32'h80808083);
      exp_wr(8'h02, 32'h00000003);
      run_job(4, 8'hFE, 8'hFF, 1'b0, 1'b0, 1'b0);

      // empty run, then a run with start pulsed mid-way
      run_job(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) mem0[i] = 32'h01020304;
      exp_wr(8'h30, 32'h01020304);
      exp_wr(8'h31, 32'h02040608);
      exp_wr(8'h32, 32'h0306090C);
      exp_wr(8'h33, 32'h04080C10);
      run_job(4, 8'h00, 8'h30, 1'b0, 1'b0, 1'b1);

      // asynchronous reset in cycle 3 of an 8-word run
      for (int i = 4; i < 8; i++) mem0[i] = 32'h01010101;
      rd_q.push_back(8'h00);
      rd_q.push_back(8'h01);
      @(negedge clk);
      run_count = 9'd8; src = 8'h00; dst = 8'h40; sat = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("midrun_reset_flags", {idle_1, run_1, done_1, read_1, write_1}, 5'b10000);
      chk("midrun_reset_bus", {ce_b0_1, ce_b1_1, we_b1_1, addr_b0_1, addr_b1_1, d_b1_1}, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      chk("midrun_reset_queues", exp_q.size() + rd_q.size(), 0);
      exp_wr(8'h50, 32'h01010101);
      exp_wr(8'h51, 32'h02020202);
      run_job(2, 8'h04, 8'h50, 1'b0, 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      chk("final_queues", exp_q.size() + rd_q.size() + exp2_q.size() + wc2_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
